// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Exception codes follow the MIPS Cause.ExcCode numbering.
package fetch_ctrl_pkg;

  localparam logic [4:0]  EC_NONE   = 5'd0;
  localparam logic [4:0]  EC_ADEL   = 5'd4;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_OUT,
    FS_DRAIN
  } fs_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  exc;
    logic [31:0] badvaddr;
  } id_ent_t;

endpackage

// File: rtl/fetch_ctrl_addr_map.sv
// Virtual to physical fetch address map (kseg0/kseg1 style)
// plus word-alignment flag for the current PC.
module fetch_ctrl_addr_map (
  input  logic [31:0] i_va,
  output logic [31:0] o_pa,
  output logic        o_aligned
);

  assign o_pa      = {3'b000, i_va[28:0]};
  assign o_aligned = (i_va[1:0] == 2'b00);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives a single
// outstanding req/gnt/rvalid bus and hands entries to ID.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [4:0]  id_exc_code_o,
  output logic [31:0] id_badvaddr_o
);

  fs_e         r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic        r_br_pend, w_br_pend;
  logic [31:0] r_br_tgt, w_br_tgt;
  logic        r_valid, w_valid;
  id_ent_t     r_ent, w_ent;

  logic [31:0] w_pa;
  logic        w_aligned;
  logic        w_req;

  fetch_ctrl_addr_map u_map (
    .i_va      (r_pc),
    .o_pa      (w_pa),
    .o_aligned (w_aligned)
  );

  // Request is a pure function of state so it cannot glitch on gnt.
  assign w_req       = rst && (r_state == FS_REQ) && w_aligned;
  assign ibus_req_o  = w_req;
  assign ibus_addr_o = w_req ? w_pa : ZERO_WORD;

  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_br_pend = r_br_pend;
    w_br_tgt  = r_br_tgt;
    w_valid   = r_valid;
    w_ent     = r_ent;

    unique case (r_state)
      FS_REQ: begin
        if (!w_aligned) begin
          w_ent   = '{r_pc, NOP_INST, EC_ADEL, r_pc};
          w_valid = 1'b1;
          w_state = FS_OUT;
        end else if (ibus_gnt_i) begin
          w_state = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (ibus_rvalid_i) begin
          w_ent   = '{r_pc, ibus_rdata_i, EC_NONE, ZERO_WORD};
          w_valid = 1'b1;
          w_state = FS_OUT;
          if (r_br_pend) begin
            w_pc      = r_br_tgt;
            w_br_pend = 1'b0;
          end else begin
            w_pc = r_pc + 32'd4;
          end
        end
      end
      FS_OUT: begin
        if (!stall_i) begin
          w_valid = 1'b0;
          w_state = FS_REQ;
        end
      end
      FS_DRAIN: begin
        if (ibus_rvalid_i) w_state = FS_REQ;
      end
      default: w_state = FS_REQ;
    endcase

    if (branch_i && !flush_i) begin
      w_br_pend = 1'b1;
      w_br_tgt  = branch_pc_i;
    end

    // A granted or in-flight request must be drained before refetching.
    if (flush_i) begin
      w_pc      = flush_pc_i;
      w_br_pend = 1'b0;
      w_valid   = 1'b0;
      unique case (1'b1)
        (r_state == FS_WAIT):
          w_state = ibus_rvalid_i ? FS_REQ : FS_DRAIN;
        (r_state == FS_REQ):
          w_state = (w_req && ibus_gnt_i) ? FS_DRAIN : FS_REQ;
        (r_state == FS_DRAIN):
          w_state = ibus_rvalid_i ? FS_REQ : FS_DRAIN;
        default:
          w_state = FS_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= FS_REQ;
      r_pc      <= RESET_PC;
      r_br_pend <= 1'b0;
      r_br_tgt  <= ZERO_WORD;
      r_valid   <= 1'b0;
      r_ent     <= '{ZERO_WORD, ZERO_WORD, EC_NONE, ZERO_WORD};
    end else begin
      r_state   <= w_state;
      r_pc      <= w_pc;
      r_br_pend <= w_br_pend;
      r_br_tgt  <= w_br_tgt;
      r_valid   <= w_valid;
      r_ent     <= w_ent;
    end
  end

  assign id_valid_o    = r_valid;
  assign id_pc_o       = r_ent.pc;
  assign id_inst_o     = r_ent.inst;
  assign id_exc_code_o = r_ent.exc;
  assign id_badvaddr_o = r_ent.badvaddr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        branch_i;
  logic [31:0] branch_pc_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [4:0]  id_exc_code_o;
  logic [31:0] id_badvaddr_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .branch_i      (branch_i),
    .branch_pc_i   (branch_pc_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_exc_code_o (id_exc_code_o),
    .id_badvaddr_o (id_badvaddr_o)
  );

  typedef struct {
    logic        st;
    logic        fl;
    logic [31:0] fpc;
    logic        br;
    logic [31:0] bpc;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic [31:0] ea;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [4:0]  eexc;
    logic [31:0] ebad;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t V(
    logic st, logic fl, logic [31:0] fpc,
    logic br, logic [31:0] bpc,
    logic g, logic rv, logic [31:0] rd,
    logic er, logic [31:0] ea, logic ev,
    logic [31:0] epc, logic [31:0] einst,
    logic [4:0] eexc, logic [31:0] ebad);
    vec_t v;
    v.st = st; v.fl = fl; v.fpc = fpc;
    v.br = br; v.bpc = bpc;
    v.g = g; v.rv = rv; v.rd = rd;
    v.er = er; v.ea = ea; v.ev = ev;
    v.epc = epc; v.einst = einst;
    v.eexc = eexc; v.ebad = ebad;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_i       = v.st;
    flush_i       = v.fl;
    flush_pc_i    = v.fpc;
    branch_i      = v.br;
    branch_pc_i   = v.bpc;
    ibus_gnt_i    = v.g;
    ibus_rvalid_i = v.rv;
    ibus_rdata_i  = v.rd;
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    rst = 1'b0;
    drive(V(0,0,Z,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req",   {31'b0, ibus_req_o}, 32'd0);
    chk("rst_addr",  ibus_addr_o, Z);
    chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_pc",    id_pc_o, Z);
    chk("rst_inst",  id_inst_o, Z);
    chk("rst_exc",   {27'b0, id_exc_code_o}, 32'd0);
    chk("rst_bad",   id_badvaddr_o, Z);

    // reset release, stall, branch delay slot
    vt.push_back(V(0,0,Z,0,Z,1,0,Z, 1,32'h1FC00000,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'h11111111, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(1,0,Z,0,Z,0,0,Z, 0,Z,1,32'hBFC00000,32'h11111111,0,Z));
    vt.push_back(V(1,0,Z,0,Z,0,1,32'hDEADBEEF, 0,Z,1,32'hBFC00000,32'h11111111,0,Z));
    vt.push_back(V(1,0,Z,0,Z,0,0,Z, 0,Z,1,32'hBFC00000,32'h11111111,0,Z));
    vt.push_back(V(1,0,Z,0,Z,0,0,Z, 0,Z,1,32'hBFC00000,32'h11111111,0,Z));
    vt.push_back(V(1,0,Z,0,Z,0,0,Z, 0,Z,1,32'hBFC00000,32'h11111111,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,1,32'hBFC00000,32'h11111111,0,Z));
    vt.push_back(V(0,0,Z,1,32'h80000100,1,0,Z, 1,32'h1FC00004,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'h22222222, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,1,32'hBFC00004,32'h22222222,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 1,32'h00000100,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 1,32'h00000100,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,1,0,Z, 1,32'h00000100,0,Z,Z,0,Z));
    // flush in WAIT -> drain
    vt.push_back(V(0,1,32'h80000180,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'hBADBAD00, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,1,0,Z, 1,32'h00000180,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'h33333333, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,1,32'h80000180,32'h33333333,0,Z));
    // misaligned flush target
    vt.push_back(V(0,1,32'h80000002,0,Z,0,0,Z, 1,32'h00000184,0,Z,Z,0,Z));
    vt.push_back(V(1,0,Z,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(1,0,Z,0,Z,0,0,Z, 0,Z,1,32'h80000002,Z,5'd4,32'h80000002));
    // flush + branch together, then flush with rvalid in WAIT
    vt.push_back(V(1,1,32'hBFC00010,1,32'h80000200,0,0,Z, 0,Z,1,32'h80000002,Z,5'd4,32'h80000002));
    vt.push_back(V(0,0,Z,0,Z,1,0,Z, 1,32'h1FC00010,0,Z,Z,0,Z));
    vt.push_back(V(0,1,32'h80000300,0,Z,0,1,32'h44444444, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,1,0,Z, 1,32'h00000300,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'h55555555, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,1,32'h80000300,32'h55555555,0,Z));
    vt.push_back(V(0,0,Z,0,Z,1,0,Z, 1,32'h00000304,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'h66666666, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,1,32'h80000304,32'h66666666,0,Z));
    // flush in REQ with gnt in the same cycle
    vt.push_back(V(0,1,32'h80000400,0,Z,1,0,Z, 1,32'h00000308,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'h99999999, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 1,32'h00000400,0,Z,Z,0,Z));
    // branch target overwritten while pending
    vt.push_back(V(0,1,32'hFFFFFFFC,0,Z,0,0,Z, 1,32'h00000400,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,1,32'h80000500,1,0,Z, 1,32'h1FFFFFFC,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,1,32'h80000600,0,0,Z, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'h77777777, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,1,32'hFFFFFFFC,32'h77777777,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 1,32'h00000600,0,Z,Z,0,Z));
    // PC wraps past 2^32
    vt.push_back(V(0,1,32'hFFFFFFFC,0,Z,0,0,Z, 1,32'h00000600,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,1,0,Z, 1,32'h1FFFFFFC,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,1,32'h88888888, 0,Z,0,Z,Z,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 0,Z,1,32'hFFFFFFFC,32'h88888888,0,Z));
    vt.push_back(V(0,0,Z,0,Z,0,0,Z, 1,32'h00000000,0,Z,Z,0,Z));

    rst = 1'b1;
    foreach (vt[i]) begin
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, ibus_req_o}, {31'b0, vt[i].er});
      chk($sformatf("v%0d_valid", i), {31'b0, id_valid_o}, {31'b0, vt[i].ev});
      if (vt[i].er)
        chk($sformatf("v%0d_addr", i), ibus_addr_o, vt[i].ea);
      if (vt[i].ev) begin
        chk($sformatf("v%0d_pc", i), id_pc_o, vt[i].epc);
        chk($sformatf("v%0d_inst", i), id_inst_o, vt[i].einst);
        chk($sformatf("v%0d_exc", i), {27'b0, id_exc_code_o}, {27'b0, vt[i].eexc});
        chk($sformatf("v%0d_bad", i), id_badvaddr_o, vt[i].ebad);
      end
      @(negedge clk);
    end

    // bounded wait for delivery of the wrapped-PC fetch
    drive(V(0,0,Z,0,Z,1,0,Z, 0,Z,0,Z,Z,0,Z));
    @(negedge clk);
    drive(V(0,0,Z,0,Z,0,1,32'hAAAA5555, 0,Z,0,Z,Z,0,Z));
    @(negedge clk);
    drive(V(0,0,Z,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z));
    begin
      int k;
      k = 0;
      while (!id_valid_o && k < 4) begin
        @(negedge clk);
        k++;
      end
      chk("wrap_timeout", {31'b0, id_valid_o}, 32'd1);
      chk("wrap_latency", k, 0);
      chk("wrap_pc", id_pc_o, 32'h00000000);
      chk("wrap_inst", id_inst_o, 32'hAAAA5555);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
